// File: rtl/dc_block_filter.sv
// dc_block_filter
//   First-order leaky high-pass that strips DC offset from the signed mono
//   sample stream:  y[n] = x[n] - x[n-1] + (1 - 2^-K) * y[n-1].
//   The accumulator holds y scaled by 2^K so that the leak term keeps
//   fractional precision.
//
// Ports
//   clk_i       system clock
//   rst_n_i     asynchronous active-low reset
//   data_i      signed input sample
//   data_val_i  one-cycle strobe qualifying data_i
//   bypass_i    1 = emit the unfiltered sample (captured with data_val_i)
//   clip_clr_i  clears clip_o and overrun_o
//   data_o      signed output sample, held between strobes
//   data_val_o  one-cycle strobe qualifying data_o
//   clip_o      sticky: an output sample or the accumulator saturated
//   overrun_o   sticky: an input strobe arrived while busy and was dropped
module dc_block_filter #(
  parameter int DATA_WIDTH = 16,
  parameter int K          = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         data_val_i,
  input  logic                         bypass_i,
  input  logic                         clip_clr_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         data_val_o,
  output logic                         clip_o,
  output logic                         overrun_o
);

  localparam int AW = DATA_WIDTH + K + 2;

  localparam logic signed [AW:0] Y_MAX =
    $signed({{(AW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [AW:0] Y_MIN =
    $signed({{(AW-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic signed [DATA_WIDTH-1:0] x_p0, x_p1, x_prev;
  logic                         byp_p0, byp_p1;
  logic signed [DATA_WIDTH:0]   diff_p0;
  logic signed [AW-1:0]         d_ext_p0;
  logic signed [AW-1:0]         d_p1, leak_p1, acc;
  logic signed [AW:0]           sum_p2, y_full_p2;
  logic                         vld_p1, vld_p2;
  logic                         acc_ovf_p2, y_ovf_p2;
  logic                         clip_set, ovr_set;

  function automatic logic signed [AW-1:0] sat_acc(input logic signed [AW:0] v);
    if (v[AW] != v[AW-1])
      sat_acc = v[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    else
      sat_acc = v[AW-1:0];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat_y(input logic signed [AW:0] v);
    if (v > Y_MAX)
      sat_y = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (v < Y_MIN)
      sat_y = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      sat_y = v[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (data_val_i) state_d = S1;
      S1:      state_d = S2;
      S2:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign vld_p1 = (state_q == S1);
  assign vld_p2 = (state_q == S2);

  always_comb begin
    diff_p0    = {x_p0[DATA_WIDTH-1], x_p0} - {x_prev[DATA_WIDTH-1], x_prev};
    d_ext_p0   = {{(K+1){diff_p0[DATA_WIDTH]}}, diff_p0};
    sum_p2     = {acc[AW-1], acc} - {leak_p1[AW-1], leak_p1} + {d_p1[AW-1], d_p1};
    y_full_p2  = sum_p2 >>> K;
    acc_ovf_p2 = (sum_p2[AW] != sum_p2[AW-1]);
    y_ovf_p2   = (y_full_p2 > Y_MAX) || (y_full_p2 < Y_MIN);
    clip_set   = vld_p2 && !byp_p1 && (acc_ovf_p2 || y_ovf_p2);
    ovr_set    = data_val_i && (state_q != IDLE);
  end

  // Stage 0 -> 1: capture accepted sample; stage 1 -> 2: difference and leak
  always_ff @(posedge clk_i) begin
    if ((state_q == IDLE) && data_val_i) begin
      x_p0   <= data_i;
      byp_p0 <= bypass_i;
    end
    if (vld_p1) begin
      d_p1    <= d_ext_p0 <<< K;
      leak_p1 <= acc >>> K;
      x_p1    <= x_p0;
      byp_p1  <= byp_p0;
    end
  end

  // Stage 2 -> out: accumulate, saturate, select bypass, sticky flags
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      x_prev     <= '0;
      acc        <= '0;
      data_o     <= '0;
      data_val_o <= 1'b0;
      clip_o     <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_val_o <= 1'b0;
      if (vld_p1)
        x_prev <= x_p0;
      if (vld_p2) begin
        acc        <= sat_acc(sum_p2);
        data_o     <= byp_p1 ? x_p1 : sat_y(y_full_p2);
        data_val_o <= 1'b1;
      end
      if (clip_set)
        clip_o <= 1'b1;
      else if (clip_clr_i)
        clip_o <= 1'b0;
      if (ovr_set)
        overrun_o <= 1'b1;
      else if (clip_clr_i)
        overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dc_block_filter.sv
// tb_dc_block_filter
//   Directed and randomized stimulus for dc_block_filter, checked against a
//   floating-point-free reference model of the leaky high-pass written with
//   plain integer arithmetic (floor division, clamping).
module tb_dc_block_filter;

  logic               clk_i;
  logic               rst_n_i;
  logic signed [15:0] data_i;
  logic               data_val_i;
  logic               bypass_i;
  logic               clip_clr_i;
  logic signed [15:0] data_o;
  logic               data_val_o;
  logic               clip_o;
  logic               overrun_o;

  int tests = 0;
  int fails = 0;

  localparam longint SC   = 256;
  localparam longint AMAX = (longint'(1) <<< 25) - 1;
  localparam longint AMIN = -(longint'(1) <<< 25);

  longint acc_m;
  longint xp_m;
  logic   clip_m;

  dc_block_filter #(.DATA_WIDTH(16), .K(8)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .data_i     (data_i),
    .data_val_i (data_val_i),
    .bypass_i   (bypass_i),
    .clip_clr_i (clip_clr_i),
    .data_o     (data_o),
    .data_val_o (data_val_o),
    .clip_o     (clip_o),
    .overrun_o  (overrun_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  task automatic model_reset();
    acc_m  = 0;
    xp_m   = 0;
    clip_m = 1'b0;
  endtask

  // One filter step: y*2^K = y_prev*2^K - floor(y_prev*2^K / 2^K) + (x - x_prev)*2^K
  task automatic model_step(input longint x, input bit b, input bit clr, output logic [15:0] out);
    longint d, leak, s, yv;
    bit sat;
    sat  = 1'b0;
    d    = (x - xp_m) * SC;
    leak = fdiv(acc_m, SC);
    s    = acc_m - leak + d;
    if (s > AMAX) begin acc_m = AMAX; sat = 1'b1; end
    else if (s < AMIN) begin acc_m = AMIN; sat = 1'b1; end
    else acc_m = s;
    yv = fdiv(s, SC);
    if (yv > 32767) begin yv = 32767; sat = 1'b1; end
    else if (yv < -32768) begin yv = -32768; sat = 1'b1; end
    xp_m = x;
    out  = b ? 16'(x) : 16'(yv);
    if (!b && sat) clip_m = 1'b1;
    else if (clr) clip_m = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk_i); #1;
    rst_n_i    = 1'b0;
    data_val_i = 1'b0;
    clip_clr_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    model_reset();
  endtask

  task automatic send(input logic signed [15:0] x, input bit b, input bit clr, input string tag);
    logic [15:0] e;
    @(posedge clk_i); #1;
    data_i = x; bypass_i = b; data_val_i = 1'b1;
    @(posedge clk_i); #1;
    data_val_i = 1'b0;
    bypass_i   = 1'($urandom_range(0, 1));
    data_i     = 16'($urandom);
    model_step(longint'(x), b, clr, e);
    @(posedge clk_i); #1;
    check1({tag, "_early"}, data_val_o, 1'b0);
    clip_clr_i = clr;
    @(posedge clk_i); #1;
    clip_clr_i = 1'b0;
    check1({tag, "_vld"}, data_val_o, 1'b1);
    check16({tag, "_data"}, data_o, e);
    check1({tag, "_clip"}, clip_o, clip_m);
    @(posedge clk_i); #1;
    check1({tag, "_vld_end"}, data_val_o, 1'b0);
    check16({tag, "_hold"}, data_o, e);
  endtask

  initial begin
    logic [15:0]        e;
    logic signed [15:0] v;
    logic signed [15:0] rx;
    int                 pulses;
    bit                 rb, rc;

    rst_n_i    = 1'b0;
    data_i     = '0;
    data_val_i = 1'b0;
    bypass_i   = 1'b0;
    clip_clr_i = 1'b0;
    model_reset();

    repeat (3) @(posedge clk_i);
    #1;
    check16("rst_data", data_o, 16'h0000);
    check1("rst_vld", data_val_o, 1'b0);
    check1("rst_clip", clip_o, 1'b0);
    check1("rst_ovr", overrun_o, 1'b0);
    rst_n_i = 1'b1;

    // Constant DC input decays away
    repeat (60) @(posedge clk_i);
    send(16'sh1000, 1'b0, 1'b0, "dc0");
    check16("dc_first", data_o, 16'h1000);
    repeat (60) @(posedge clk_i);
    send(16'sh1000, 1'b0, 1'b0, "dc1");
    check16("dc_second", data_o, 16'h0FF0);
    for (int i = 2; i < 4096; i++)
      send(16'sh1000, 1'b0, 1'b0, "dc");
    v = data_o;
    check1("dc_settled", (v >= -16'sd1) && (v <= 16'sd1), 1'b1);
    check1("dc_noclip", clip_o, 1'b0);

    // Full-scale step saturates, clip is sticky until cleared
    reset_dut();
    send(16'sh7FFF, 1'b0, 1'b0, "sat0");
    send(-16'sh8000, 1'b0, 1'b0, "sat1");
    check16("sat_value", data_o, 16'h8000);
    check1("sat_clip", clip_o, 1'b1);
    repeat (10) @(posedge clk_i);
    #1;
    check1("clip_sticky", clip_o, 1'b1);
    clip_clr_i = 1'b1;
    @(posedge clk_i); #1;
    clip_clr_i = 1'b0;
    clip_m = 1'b0;
    check1("clip_cleared", clip_o, 1'b0);

    // Bypass passes input through while filter state keeps tracking
    reset_dut();
    send(16'sh1234, 1'b1, 1'b0, "byp0");
    check16("byp_a", data_o, 16'h1234);
    send(-16'sh0124, 1'b1, 1'b0, "byp1");
    check16("byp_b", data_o, 16'hFEDC);
    send(16'sh7FFF, 1'b1, 1'b0, "byp2");
    send(-16'sh8000, 1'b1, 1'b0, "byp3");
    check1("byp_noclip", clip_o, 1'b0);
    send(16'sh0321, 1'b0, 1'b0, "byp_off");

    // Back-to-back strobes: second one dropped, overrun flagged
    reset_dut();
    @(posedge clk_i); #1;
    data_i = 16'sh0400; bypass_i = 1'b0; data_val_i = 1'b1;
    @(posedge clk_i); #1;
    data_i = 16'sh7000; data_val_i = 1'b1;
    model_step(longint'(16'sh0400), 1'b0, 1'b0, e);
    @(posedge clk_i); #1;
    data_val_i = 1'b0;
    check1("ovr_flag", overrun_o, 1'b1);
    check1("ovr_early", data_val_o, 1'b0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1;
      if (data_val_o) begin
        pulses++;
        check16("ovr_data", data_o, e);
      end
    end
    check16("ovr_pulses", 16'(pulses), 16'd1);
    check1("ovr_sticky", overrun_o, 1'b1);
    clip_clr_i = 1'b1;
    @(posedge clk_i); #1;
    clip_clr_i = 1'b0;
    check1("ovr_cleared", overrun_o, 1'b0);
    send(16'sh0400, 1'b0, 1'b0, "post_ovr");

    // Asynchronous reset while a sample is in S1
    @(posedge clk_i); #1;
    data_i = 16'sh2000; bypass_i = 1'b0; data_val_i = 1'b1;
    @(posedge clk_i); #1;
    data_val_i = 1'b0;
    #2;
    rst_n_i = 1'b0;
    #1;
    check16("arst_data", data_o, 16'h0000);
    check1("arst_vld", data_val_o, 1'b0);
    check1("arst_clip", clip_o, 1'b0);
    check1("arst_ovr", overrun_o, 1'b0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      check1("arst_no_pulse", data_val_o, 1'b0);
    end
    send(16'sh0100, 1'b0, 1'b0, "arst_next");
    check16("arst_next_val", data_o, 16'h0100);

    // Clear coinciding with a new saturation: set wins
    reset_dut();
    send(16'sh7FFF, 1'b0, 1'b0, "prio0");
    send(-16'sh8000, 1'b0, 1'b1, "prio1");
    check1("prio_clip", clip_o, 1'b1);

    // Randomized samples, bypass and clears against the reference model
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0)
        rx = 16'($urandom);
      else
        rx = 16'($signed($urandom_range(0, 2047)) - 1024);
      rb = ($urandom_range(0, 3) == 0);
      rc = ($urandom_range(0, 7) == 0);
      send(rx, rb, rc, "rnd");
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
